tpu_host_driver: RTL and testbench



---
 rtl/tpu_host_driver_if.sv | 46 ++++
 rtl/tpu_host_driver.sv | 228 ++++++++++++++++++++++
 tb/tb_tpu_host_driver.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_host_driver_if.sv
// Host-side bus of the TPU host driver: command descriptors, the write-row
// source stream, the result-row sink stream and per-command status.
interface tpu_host_driver_if #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_MAT_WH   = 128,
  parameter int ADDR_WIDTH   = 8
);
  localparam int DIM_W = $clog2(MAX_MAT_WH) + 1;
  localparam int WR_W  = WIDTH_HEIGHT * DATA_WIDTH;
  localparam int RD_W  = 2 * WR_W;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_opcode;
  logic [DIM_W-1:0]      cmd_dim_1;
  logic [DIM_W-1:0]      cmd_dim_2;
  logic [DIM_W-1:0]      cmd_dim_3;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [2:0]            cmd_submat_row;
  logic [2:0]            cmd_submat_col;

  logic                  src_valid;
  logic                  src_ready;
  logic [WR_W-1:0]       src_data;

  logic                  snk_valid;
  logic                  snk_ready;
  logic [RD_W-1:0]       snk_data;

  logic                  cmd_done;
  logic                  cmd_err;
  logic [1:0]            err_code;

  modport master (
    output cmd_valid, cmd_opcode, cmd_dim_1, cmd_dim_2, cmd_dim_3, cmd_addr,
           cmd_submat_row, cmd_submat_col, src_valid, src_data, snk_ready,
    input  cmd_ready, src_ready, snk_valid, snk_data, cmd_done, cmd_err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_dim_1, cmd_dim_2, cmd_dim_3, cmd_addr,
           cmd_submat_row, cmd_submat_col, src_valid, src_data, snk_ready,
    output cmd_ready, src_ready, snk_valid, snk_data, cmd_done, cmd_err, err_code
  );
endinterface

// File: rtl/tpu_host_driver.sv
// Host-side initiator for the TPU command port: stages write rows, issues
// start/opcode/dims, feeds or captures rows in the data phase, reports status.
module tpu_host_driver #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_MAT_WH   = 128,
  parameter int ADDR_WIDTH   = 8,
  parameter int TIMEOUT      = 4096,
  localparam int DIM_W = $clog2(MAX_MAT_WH) + 1,
  localparam int WR_W  = WIDTH_HEIGHT * DATA_WIDTH,
  localparam int RD_W  = 2 * WR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tpu_host_driver_if.slave      host,
  output logic                  start,
  output logic [2:0]            opcode,
  output logic [DIM_W-1:0]      dim_1,
  output logic [DIM_W-1:0]      dim_2,
  output logic [DIM_W-1:0]      dim_3,
  output logic [ADDR_WIDTH-1:0] addr_1,
  output logic [2:0]            accum_table_submat_row_in,
  output logic [2:0]            accum_table_submat_col_in,
  input  logic                  done,
  input  logic                  fifo_ready,
  output logic [WR_W-1:0]       inputMem_wr_data,
  output logic [WR_W-1:0]       weightMem_wr_data,
  input  logic [RD_W-1:0]       outputMem_rd_data
);
  localparam int PTR_W = $clog2(WIDTH_HEIGHT);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(WIDTH_HEIGHT);

  localparam logic [2:0] OP_WR_INPUT  = 3'd1;
  localparam logic [2:0] OP_WR_WEIGHT = 3'd2;
  localparam logic [2:0] OP_RD_OUTPUT = 3'd6;
  localparam logic [2:0] OP_CLEAR     = 3'd7;

  typedef enum logic [2:0] {IDLE, FILL, SPACE, ISSUE, XFER, WAIT_DONE} state_t;

  state_t state_q, state_d;
  logic   init_q;

  logic [WR_W-1:0]  stg_mem [WIDTH_HEIGHT];
  logic [PTR_W-1:0] stg_wp, stg_rp;
  logic [CNT_W-1:0] stg_cnt;

  logic [RD_W-1:0]  res_mem [WIDTH_HEIGHT];
  logic [PTR_W-1:0] res_wp, res_rp;
  logic [CNT_W-1:0] res_cnt;

  logic [CNT_W-1:0] xfer_cnt, cap_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             rd_pend, done_seen;
  logic             cmd_done_q, cmd_err_q;
  logic [1:0]       err_code_q;

  logic accept, new_wr, new_rd, bad_dim, op_wr, op_rd;
  logic push_src, stg_pop, rd_req, res_pop, res_full, res_push_ok, overflow;
  logic clear_res, done_now, tmo_err;
  logic [CNT_W-1:0] stg_cnt_nxt;

  always_comb begin
    accept      = (state_q == IDLE) && init_q && host.cmd_valid;
    new_wr      = (host.cmd_opcode == OP_WR_INPUT) || (host.cmd_opcode == OP_WR_WEIGHT);
    new_rd      = (host.cmd_opcode == OP_RD_OUTPUT);
    bad_dim     = (new_wr || new_rd) &&
                  ((host.cmd_dim_1 == '0) || (host.cmd_dim_1 > DIM_W'(WIDTH_HEIGHT)));
    op_wr       = (opcode == OP_WR_INPUT) || (opcode == OP_WR_WEIGHT);
    op_rd       = (opcode == OP_RD_OUTPUT);
    push_src    = host.src_valid && host.src_ready;
    stg_cnt_nxt = stg_cnt + CNT_W'(push_src);
    stg_pop     = (state_q == XFER) && op_wr && fifo_ready && (stg_cnt != '0) &&
                  (DIM_W'(xfer_cnt) < dim_1);
    rd_req      = (state_q == XFER) && op_rd && fifo_ready && (DIM_W'(xfer_cnt) < dim_1);
    res_pop     = host.snk_valid && host.snk_ready;
    res_full    = (res_cnt == DEPTH);
    res_push_ok = rd_pend && (!res_full || res_pop);
    overflow    = rd_pend && res_full && !res_pop;
    clear_res   = (state_q == ISSUE) && (opcode == OP_CLEAR);
    done_now    = (state_q == WAIT_DONE) && (done || done_seen);
    tmo_err     = ((state_q == XFER) || (state_q == WAIT_DONE)) && !done_now &&
                  (tmo_cnt == TMO_W'(TIMEOUT - 1));
  end

  // Next-state logic; a timeout in XFER or WAIT_DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !bad_dim) begin
          if (new_wr)      state_d = FILL;
          else if (new_rd) state_d = SPACE;
          else             state_d = ISSUE;
        end
      end
      FILL:  if (DIM_W'(stg_cnt_nxt) == dim_1) state_d = ISSUE;
      SPACE: if (DIM_W'(DEPTH - res_cnt) >= dim_1) state_d = ISSUE;
      ISSUE: state_d = (op_wr || op_rd) ? XFER : WAIT_DONE;
      XFER: begin
        if (tmo_err)
          state_d = IDLE;
        else if (stg_pop && (DIM_W'(xfer_cnt + CNT_W'(1)) == dim_1))
          state_d = WAIT_DONE;
        else if (op_rd && rd_pend && (DIM_W'(cap_cnt + CNT_W'(1)) == dim_1))
          state_d = WAIT_DONE;
      end
      WAIT_DONE: if (done_now || tmo_err) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start            = (state_q == ISSUE);
  assign host.cmd_ready   = (state_q == IDLE) && init_q;
  assign host.src_ready   = (state_q == FILL) && (DIM_W'(stg_cnt) < dim_1);
  assign host.snk_valid   = (res_cnt != '0);
  assign host.snk_data    = host.snk_valid ? res_mem[res_rp] : '0;
  assign host.cmd_done    = cmd_done_q;
  assign host.cmd_err     = cmd_err_q;
  assign host.err_code    = err_code_q;
  assign inputMem_wr_data  = (stg_pop && (opcode == OP_WR_INPUT))  ? stg_mem[stg_rp] : '0;
  assign weightMem_wr_data = (stg_pop && (opcode == OP_WR_WEIGHT)) ? stg_mem[stg_rp] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                   <= IDLE;
      init_q                    <= 1'b0;
      opcode                    <= '0;
      dim_1                     <= '0;
      dim_2                     <= '0;
      dim_3                     <= '0;
      addr_1                    <= '0;
      accum_table_submat_row_in <= '0;
      accum_table_submat_col_in <= '0;
      done_seen                 <= 1'b0;
      cmd_done_q                <= 1'b0;
      cmd_err_q                 <= 1'b0;
      err_code_q                <= '0;
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b1;
      cmd_done_q <= done_now;
      cmd_err_q  <= 1'b0;
      if (accept) begin
        opcode                    <= host.cmd_opcode;
        dim_1                     <= host.cmd_dim_1;
        dim_2                     <= host.cmd_dim_2;
        dim_3                     <= host.cmd_dim_3;
        addr_1                    <= host.cmd_addr;
        accum_table_submat_row_in <= host.cmd_submat_row;
        accum_table_submat_col_in <= host.cmd_submat_col;
        done_seen                 <= 1'b0;
      end else if (((state_q == ISSUE) || (state_q == XFER)) && done) begin
        done_seen <= 1'b1;
      end
      if (accept && bad_dim) begin
        cmd_err_q  <= 1'b1;
        err_code_q <= 2'd1;
      end
      if (tmo_err) begin
        cmd_err_q  <= 1'b1;
        err_code_q <= 2'd2;
      end
      if (overflow) begin
        cmd_err_q  <= 1'b1;
        err_code_q <= 2'd3;
      end
    end
  end

  // Per-command counters restart at ISSUE; xfer_cnt counts pops or read requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      xfer_cnt <= '0;
      cap_cnt  <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= rd_req;
      if (state_q == ISSUE) begin
        tmo_cnt  <= TMO_W'(1);
        xfer_cnt <= '0;
        cap_cnt  <= '0;
      end else begin
        if ((state_q == XFER) || (state_q == WAIT_DONE)) tmo_cnt <= tmo_cnt + TMO_W'(1);
        if (stg_pop || rd_req) xfer_cnt <= xfer_cnt + CNT_W'(1);
        if (rd_pend) cap_cnt <= cap_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_wp  <= '0;
      stg_rp  <= '0;
      stg_cnt <= '0;
      res_wp  <= '0;
      res_rp  <= '0;
      res_cnt <= '0;
    end else begin
      if (tmo_err) begin
        stg_wp  <= '0;
        stg_rp  <= '0;
        stg_cnt <= '0;
      end else begin
        if (push_src) stg_wp <= stg_wp + PTR_W'(1);
        if (stg_pop)  stg_rp <= stg_rp + PTR_W'(1);
        stg_cnt <= stg_cnt_nxt - CNT_W'(stg_pop);
      end
      if (clear_res) begin
        res_wp  <= '0;
        res_rp  <= '0;
        res_cnt <= '0;
      end else begin
        if (res_push_ok) res_wp <= res_wp + PTR_W'(1);
        if (res_pop)     res_rp <= res_rp + PTR_W'(1);
        res_cnt <= res_cnt + CNT_W'(res_push_ok) - CNT_W'(res_pop);
      end
    end
  end

  // Row storage carries no reset; validity comes from the pointers above.
  always_ff @(posedge clk) begin
    if (push_src)    stg_mem[stg_wp] <= host.src_data;
    if (res_push_ok) res_mem[res_wp] <= outputMem_rd_data;
  end
endmodule

// File: tb/tb_tpu_host_driver.sv
// Directed self-checking bench for tpu_host_driver with a hand-driven TPU side.
module tb_tpu_host_driver;
  localparam int WR_W = 128;
  localparam int RD_W = 256;
  localparam logic [2:0] OP_NOP = 3'd0, OP_WR_INPUT = 3'd1, OP_WR_WEIGHT = 3'd2;
  localparam logic [2:0] OP_MATMUL = 3'd5, OP_RD_OUTPUT = 3'd6, OP_CLEAR = 3'd7;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [2:0]      opcode;
  logic [7:0]      dim_1, dim_2, dim_3;
  logic [7:0]      addr_1;
  logic [2:0]      submat_row, submat_col;
  logic            done;
  logic            fifo_ready;
  logic [WR_W-1:0] inputMem_wr_data, weightMem_wr_data;
  logic [RD_W-1:0] outputMem_rd_data;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  tpu_host_driver_if host_if ();

  tpu_host_driver #(.TIMEOUT(64)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .host                      (host_if),
    .start                     (start),
    .opcode                    (opcode),
    .dim_1                     (dim_1),
    .dim_2                     (dim_2),
    .dim_3                     (dim_3),
    .addr_1                    (addr_1),
    .accum_table_submat_row_in (submat_row),
    .accum_table_submat_col_in (submat_col),
    .done                      (done),
    .fifo_ready                (fifo_ready),
    .inputMem_wr_data          (inputMem_wr_data),
    .weightMem_wr_data         (weightMem_wr_data),
    .outputMem_rd_data         (outputMem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WR_W-1:0] row_w(input int i);
    return {4{32'hA5A5_0000 + 32'(i)}};
  endfunction

  function automatic logic [RD_W-1:0] row_r(input int i);
    return {8{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    int k;
    host_if.cmd_opcode     = op;
    host_if.cmd_dim_1      = d1;
    host_if.cmd_dim_2      = d2;
    host_if.cmd_dim_3      = d3;
    host_if.cmd_addr       = 8'h3C;
    host_if.cmd_submat_row = 3'd5;
    host_if.cmd_submat_col = 3'd2;
    host_if.cmd_valid      = 1'b1;
    k = 0;
    while (!host_if.cmd_ready && k < 200) begin step(); k++; end
    vec_cnt++;
    if (!host_if.cmd_ready) begin
      $display("[TB] FAIL cmd_accept_timeout: cmd_ready got 0 expected 1"); miss_cnt++;
    end
    step();
    host_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_start();
    int k;
    k = 0;
    while (start !== 1'b1 && k < 40) begin step(); k++; end
    vec_cnt++;
    if (start !== 1'b1) begin
      $display("[TB] FAIL start_timeout: start got %b expected 1", start); miss_cnt++;
    end
  endtask

  task automatic run_read(input int n, input int base);
    send_cmd(OP_RD_OUTPUT, 8'(n), 8'd0, 8'd0);
    wait_start();
    step();
    for (int c = 0; c <= n; c++) begin
      fifo_ready        = (c < n);
      outputMem_rd_data = (c > 0) ? row_r(base + c - 1) : '0;
      step();
    end
    fifo_ready        = 1'b0;
    outputMem_rd_data = '0;
    done = 1'b1;
    step();
    done = 1'b0;
    vec_cnt++;
    if (host_if.cmd_done !== 1'b1) begin
      $display("[TB] FAIL rd_cmd_done: got %b expected 1", host_if.cmd_done); miss_cnt++;
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    vec_cnt++;
    if ({host_if.cmd_ready, start, host_if.src_ready, host_if.snk_valid,
         host_if.cmd_done, host_if.cmd_err, host_if.err_code} !== 8'h00) begin
      $display("[TB] FAIL reset_ctrl: got rdy=%b start=%b src=%b snk=%b done=%b err=%b code=%0d expected all 0",
               host_if.cmd_ready, start, host_if.src_ready, host_if.snk_valid,
               host_if.cmd_done, host_if.cmd_err, host_if.err_code);
      miss_cnt++;
    end
    vec_cnt++;
    if ({opcode, dim_1, dim_2, dim_3, addr_1, submat_row, submat_col} !== '0 ||
        inputMem_wr_data !== '0 || weightMem_wr_data !== '0) begin
      $display("[TB] FAIL reset_tpu_port: got op=%0d d1=%0d addr=%0h in=%0h expected 0",
               opcode, dim_1, addr_1, inputMem_wr_data);
      miss_cnt++;
    end
    rst_n = 1'b1;
    #1;
    vec_cnt++;
    if (host_if.cmd_ready !== 1'b0) begin
      $display("[TB] FAIL ready_before_edge: got %b expected 0", host_if.cmd_ready); miss_cnt++;
    end
    step();
    vec_cnt++;
    if (host_if.cmd_ready !== 1'b1) begin
      $display("[TB] FAIL ready_after_edge: got %b expected 1", host_if.cmd_ready); miss_cnt++;
    end
  endtask

  task automatic test_write_input();
    int k;
    send_cmd(OP_WR_INPUT, 8'd4, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      host_if.src_valid = 1'b1;
      host_if.src_data  = row_w(i);
      k = 0;
      while (!host_if.src_ready && k < 20) begin step(); k++; end
      step();
    end
    host_if.src_valid = 1'b0;
    vec_cnt++;
    if (start !== 1'b1 || opcode !== OP_WR_INPUT || dim_1 !== 8'd4 || addr_1 !== 8'h3C) begin
      $display("[TB] FAIL wr_start: got start=%b op=%0d d1=%0d addr=%0h expected 1/1/4/3c",
               start, opcode, dim_1, addr_1);
      miss_cnt++;
    end
    step();
    for (int i = 0; i < 4; i++) begin
      fifo_ready = 1'b1;
      #1;
      vec_cnt++;
      if (inputMem_wr_data !== row_w(i) || weightMem_wr_data !== '0) begin
        $display("[TB] FAIL wr_row%0d: got in=%0h w=%0h expected in=%0h w=0",
                 i, inputMem_wr_data, weightMem_wr_data, row_w(i));
        miss_cnt++;
      end
      step();
    end
    fifo_ready = 1'b0;
    step();
    vec_cnt++;
    if (host_if.cmd_done !== 1'b0) begin
      $display("[TB] FAIL wr_done_early: got %b expected 0", host_if.cmd_done); miss_cnt++;
    end
    done = 1'b1;
    step();
    done = 1'b0;
    vec_cnt++;
    if (host_if.cmd_done !== 1'b1) begin
      $display("[TB] FAIL wr_cmd_done: got %b expected 1", host_if.cmd_done); miss_cnt++;
    end
    step();
    vec_cnt++;
    if (host_if.cmd_done !== 1'b0 || host_if.cmd_ready !== 1'b1) begin
      $display("[TB] FAIL wr_back_idle: got done=%b rdy=%b expected 0/1",
               host_if.cmd_done, host_if.cmd_ready);
      miss_cnt++;
    end
  endtask

  task automatic test_read_output();
    run_read(16, 0);
    host_if.snk_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vec_cnt++;
      if (host_if.snk_valid !== 1'b1 || host_if.snk_data !== row_r(i)) begin
        $display("[TB] FAIL rd_row%0d: got v=%b d=%0h expected v=1 d=%0h",
                 i, host_if.snk_valid, host_if.snk_data, row_r(i));
        miss_cnt++;
      end
      step();
    end
    vec_cnt++;
    if (host_if.snk_valid !== 1'b0) begin
      $display("[TB] FAIL rd_empty_after_16: got %b expected 0", host_if.snk_valid); miss_cnt++;
    end
    host_if.snk_ready = 1'b0;
  endtask

  task automatic test_matmul();
    send_cmd(OP_MATMUL, 8'd32, 8'd32, 8'd32);
    vec_cnt++;
    if (start !== 1'b1 || opcode !== OP_MATMUL || dim_1 !== 8'd32 || dim_2 !== 8'd32 ||
        dim_3 !== 8'd32 || submat_row !== 3'd5 || submat_col !== 3'd2) begin
      $display("[TB] FAIL mm_issue: got start=%b op=%0d dims=%0d/%0d/%0d sub=%0d/%0d expected 1/5/32/32/32/5/2",
               start, opcode, dim_1, dim_2, dim_3, submat_row, submat_col);
      miss_cnt++;
    end
    step();
    vec_cnt++;
    if (start !== 1'b0) begin
      $display("[TB] FAIL mm_start_width: got %b expected 0", start); miss_cnt++;
    end
    step(); step();
    vec_cnt++;
    if (host_if.cmd_done !== 1'b0 || dim_3 !== 8'd32) begin
      $display("[TB] FAIL mm_wait: got done=%b d3=%0d expected 0/32", host_if.cmd_done, dim_3);
      miss_cnt++;
    end
    done = 1'b1;
    step();
    done = 1'b0;
    vec_cnt++;
    if (host_if.cmd_done !== 1'b1) begin
      $display("[TB] FAIL mm_cmd_done: got %b expected 1", host_if.cmd_done); miss_cnt++;
    end
    step();
  endtask

  task automatic test_early_done();
    send_cmd(OP_NOP, 8'd0, 8'd0, 8'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    vec_cnt++;
    if (host_if.cmd_done !== 1'b0) begin
      $display("[TB] FAIL early_done_pulse: got %b expected 0", host_if.cmd_done); miss_cnt++;
    end
    step();
    vec_cnt++;
    if (host_if.cmd_done !== 1'b1) begin
      $display("[TB] FAIL early_done_honoured: got %b expected 1", host_if.cmd_done); miss_cnt++;
    end
    step();
  endtask

  task automatic test_bad_dim();
    logic [7:0] bad [2];
    bad[0] = 8'd0;
    bad[1] = 8'd17;
    for (int i = 0; i < 2; i++) begin
      send_cmd(OP_WR_WEIGHT, bad[i], 8'd0, 8'd0);
      vec_cnt++;
      if (host_if.cmd_err !== 1'b1 || host_if.err_code !== 2'd1 || start !== 1'b0 ||
          host_if.cmd_ready !== 1'b1) begin
        $display("[TB] FAIL bad_dim_%0d: got err=%b code=%0d start=%b rdy=%b expected 1/1/0/1",
                 bad[i], host_if.cmd_err, host_if.err_code, start, host_if.cmd_ready);
        miss_cnt++;
      end
      step();
      vec_cnt++;
      if (host_if.cmd_err !== 1'b0 || host_if.err_code !== 2'd1 || start !== 1'b0) begin
        $display("[TB] FAIL bad_dim_after_%0d: got err=%b code=%0d start=%b expected 0/1/0",
                 bad[i], host_if.cmd_err, host_if.err_code, start);
        miss_cnt++;
      end
    end
  endtask

  task automatic test_timeout();
    send_cmd(OP_MATMUL, 8'd8, 8'd8, 8'd8);
    vec_cnt++;
    if (start !== 1'b1) begin
      $display("[TB] FAIL tmo_start: got %b expected 1", start); miss_cnt++;
    end
    for (int k = 1; k < 64; k++) step();
    vec_cnt++;
    if (host_if.cmd_err !== 1'b0 || host_if.cmd_ready !== 1'b0) begin
      $display("[TB] FAIL tmo_early: got err=%b rdy=%b expected 0/0", host_if.cmd_err, host_if.cmd_ready);
      miss_cnt++;
    end
    step();
    vec_cnt++;
    if (host_if.cmd_err !== 1'b1 || host_if.err_code !== 2'd2 || host_if.cmd_ready !== 1'b1 ||
        host_if.cmd_done !== 1'b0) begin
      $display("[TB] FAIL tmo_fire: got err=%b code=%0d rdy=%b done=%b expected 1/2/1/0",
               host_if.cmd_err, host_if.err_code, host_if.cmd_ready, host_if.cmd_done);
      miss_cnt++;
    end
    step();
  endtask

  task automatic test_clear();
    run_read(2, 50);
    vec_cnt++;
    if (host_if.snk_valid !== 1'b1 || host_if.snk_data !== row_r(50)) begin
      $display("[TB] FAIL clr_before: got v=%b d=%0h expected v=1 d=%0h",
               host_if.snk_valid, host_if.snk_data, row_r(50));
      miss_cnt++;
    end
    send_cmd(OP_CLEAR, 8'd0, 8'd0, 8'd0);
    wait_start();
    step();
    vec_cnt++;
    if (host_if.snk_valid !== 1'b0) begin
      $display("[TB] FAIL clr_empties: got %b expected 0", host_if.snk_valid); miss_cnt++;
    end
    done = 1'b1;
    step();
    done = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    run_read(1, 100);
    send_cmd(OP_WR_INPUT, 8'd2, 8'd0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      host_if.src_valid = 1'b1;
      host_if.src_data  = row_w(10 + i);
      step();
    end
    host_if.src_valid = 1'b0;
    wait_start();
    step();
    fifo_ready = 1'b1;
    #1;
    vec_cnt++;
    if (inputMem_wr_data !== row_w(10)) begin
      $display("[TB] FAIL rstmid_xfer: got %0h expected %0h", inputMem_wr_data, row_w(10));
      miss_cnt++;
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (inputMem_wr_data !== '0 || start !== 1'b0 || host_if.cmd_ready !== 1'b0 ||
        host_if.snk_valid !== 1'b0 || opcode !== 3'd0 || dim_1 !== 8'd0 ||
        host_if.cmd_done !== 1'b0 || host_if.cmd_err !== 1'b0 || host_if.src_ready !== 1'b0) begin
      $display("[TB] FAIL rstmid_outputs: got in=%0h start=%b rdy=%b snk=%b op=%0d d1=%0d done=%b err=%b expected all 0",
               inputMem_wr_data, start, host_if.cmd_ready, host_if.snk_valid, opcode, dim_1,
               host_if.cmd_done, host_if.cmd_err);
      miss_cnt++;
    end
    fifo_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    vec_cnt++;
    if (host_if.cmd_ready !== 1'b1 || host_if.snk_valid !== 1'b0 || host_if.cmd_err !== 1'b0) begin
      $display("[TB] FAIL rstmid_release: got rdy=%b snk=%b err=%b expected 1/0/0",
               host_if.cmd_ready, host_if.snk_valid, host_if.cmd_err);
      miss_cnt++;
    end
    send_cmd(OP_NOP, 8'd0, 8'd0, 8'd0);
    vec_cnt++;
    if (start !== 1'b1 || opcode !== OP_NOP) begin
      $display("[TB] FAIL rstmid_nop_start: got start=%b op=%0d expected 1/0", start, opcode);
      miss_cnt++;
    end
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    vec_cnt++;
    if (host_if.cmd_done !== 1'b1) begin
      $display("[TB] FAIL rstmid_nop_done: got %b expected 1", host_if.cmd_done); miss_cnt++;
    end
    step();
  endtask

  initial begin
    rst_n                  = 1'b0;
    done                   = 1'b0;
    fifo_ready             = 1'b0;
    outputMem_rd_data      = '0;
    host_if.cmd_valid      = 1'b0;
    host_if.cmd_opcode     = '0;
    host_if.cmd_dim_1      = '0;
    host_if.cmd_dim_2      = '0;
    host_if.cmd_dim_3      = '0;
    host_if.cmd_addr       = '0;
    host_if.cmd_submat_row = '0;
    host_if.cmd_submat_col = '0;
    host_if.src_valid      = 1'b0;
    host_if.src_data       = '0;
    host_if.snk_ready      = 1'b0;

    test_reset();
    test_write_input();
    test_read_output();
    test_matmul();
    test_early_done();
    test_bad_dim();
    test_timeout();
    test_clear();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation got stuck, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
